// File: rtl/counter_register_if.sv
//------------------------------------------------------------------------------
// Module   : counter_register_if
// Brief    : Bus, count-control and status signals of counter_register.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface counter_register_if #(
    parameter int INPUT_COUNT  = 2,
    parameter int OUTPUT_COUNT = 2,
    parameter int WIDTH        = 8
);
    logic [WIDTH*INPUT_COUNT-1:0]  busInputs;
    logic [INPUT_COUNT-1:0]        busReadEnable;
    logic [OUTPUT_COUNT-1:0]       busWriteEnable;
    logic [WIDTH*OUTPUT_COUNT-1:0] busOutputs;
    logic                          inc;
    logic                          dec;
    logic                          clear;
    logic [WIDTH-1:0]              value;
    logic                          zero;
    logic                          wrap;

    modport master (
        output busInputs, busReadEnable, busWriteEnable, inc, dec, clear,
        input  busOutputs, value, zero, wrap
    );

    modport slave (
        input  busInputs, busReadEnable, busWriteEnable, inc, dec, clear,
        output busOutputs, value, zero, wrap
    );
endinterface

`default_nettype wire

// File: rtl/counter_register.sv
//------------------------------------------------------------------------------
// Module   : counter_register
// Brief    : Bus-loadable up/down counting register with wrap flag and gated
//            bus outputs.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module counter_register #(
    parameter int               INPUT_COUNT   = 2,
    parameter int               OUTPUT_COUNT  = 2,
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
    parameter int               STEP          = 1
) (
    input  wire logic           clk,
    input  wire logic           nrst,
    counter_register_if.slave   bus
);
    localparam logic [WIDTH:0] c_step = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] r_value;
    logic             r_wrap;

    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_next_value;
    logic             w_next_wrap;

    // Later iterations override earlier ones, so the highest enabled index wins.
    always_comb begin
        w_load_data = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            if (bus.busReadEnable[i]) begin
                w_load_data = bus.busInputs[WIDTH*i +: WIDTH];
            end
        end
    end

    assign w_load = |bus.busReadEnable;
    assign w_sum  = {1'b0, r_value} + c_step;
    assign w_diff = {1'b0, r_value} - c_step;

    always_comb begin
        w_next_value = r_value;
        w_next_wrap  = 1'b0;
        if (bus.clear) begin
            w_next_value = DEFAULT_VALUE;
        end else if (w_load) begin
            w_next_value = w_load_data;
        end else if (bus.inc && bus.dec) begin
            w_next_value = r_value;
        end else if (bus.inc) begin
            w_next_value = w_sum[WIDTH-1:0];
            w_next_wrap  = w_sum[WIDTH];
        end else if (bus.dec) begin
            w_next_value = w_diff[WIDTH-1:0];
            w_next_wrap  = w_diff[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_value <= DEFAULT_VALUE;
            r_wrap  <= 1'b0;
        end else begin
            r_value <= w_next_value;
            r_wrap  <= w_next_wrap;
        end
    end

    assign bus.value = r_value;
    assign bus.zero  = (r_value == '0);
    assign bus.wrap  = r_wrap;

    generate
        for (genvar j = 0; j < OUTPUT_COUNT; j++) begin : g_out
            assign bus.busOutputs[WIDTH*j +: WIDTH] =
                bus.busWriteEnable[j] ? r_value : '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_counter_register.sv
//------------------------------------------------------------------------------
// Module   : tb_counter_register
// Brief    : Scoreboard bench for counter_register, STEP=1 and STEP=4 instances.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter_register;
    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    counter_register_if #(.INPUT_COUNT(2), .OUTPUT_COUNT(2), .WIDTH(8)) if1 ();
    counter_register_if #(.INPUT_COUNT(2), .OUTPUT_COUNT(2), .WIDTH(8)) if4 ();

    counter_register #(
        .INPUT_COUNT(2), .OUTPUT_COUNT(2), .WIDTH(8),
        .DEFAULT_VALUE(8'hFD), .STEP(1)
    ) u_dut1 (.clk(clk), .nrst(nrst), .bus(if1));

    counter_register #(
        .INPUT_COUNT(2), .OUTPUT_COUNT(2), .WIDTH(8),
        .DEFAULT_VALUE(8'hFD), .STEP(4)
    ) u_dut4 (.clk(clk), .nrst(nrst), .bus(if4));

    typedef struct {
        string      tag;
        logic [7:0] v1;
        logic       w1;
        logic [7:0] v4;
        logic       w4;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         fails  = 0;
    logic [7:0] m1v, m4v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: carry/borrow come from range, not from a bit.
    function automatic logic [8:0] model_next(input logic [7:0] v, input int stp,
            input logic [15:0] bi, input logic [1:0] re,
            input logic inc, input logic dec, input logic clr);
        int s;
        if (clr)         return {1'b0, 8'hFD};
        if (re[1])       return {1'b0, bi[15:8]};
        if (re[0])       return {1'b0, bi[7:0]};
        if (inc && dec)  return {1'b0, v};
        if (inc) begin
            s = int'(v) + stp;
            return {(s > 255), 8'(s % 256)};
        end
        if (dec) begin
            s = int'(v) - stp;
            return {(s < 0), 8'((s + 256) % 256)};
        end
        return {1'b0, v};
    endfunction

    function automatic logic [15:0] gate(input logic [7:0] v, input logic [1:0] we);
        logic [15:0] r;
        r[15:8] = we[1] ? v : 8'h00;
        r[7:0]  = we[0] ? v : 8'h00;
        return r;
    endfunction

    task automatic drive(input logic [15:0] bi, input logic [1:0] re, input logic [1:0] we,
                         input logic inc, input logic dec, input logic clr);
        if1.busInputs = bi;  if1.busReadEnable = re; if1.busWriteEnable = we;
        if1.inc = inc;       if1.dec = dec;          if1.clear = clr;
        if4.busInputs = bi;  if4.busReadEnable = re; if4.busWriteEnable = we;
        if4.inc = inc;       if4.dec = dec;          if4.clear = clr;
    endtask

    task automatic step(input string tag, input logic [15:0] bi, input logic [1:0] re,
                        input logic [1:0] we, input logic inc, input logic dec,
                        input logic clr);
        exp_t       e;
        logic [8:0] n1, n4;
        @(negedge clk);
        drive(bi, re, we, inc, dec, clr);
        #1;
        // Before the edge the outputs must still show the old contents.
        chk({tag, ":pre_out1"}, 32'(if1.busOutputs), 32'(gate(m1v, we)));
        chk({tag, ":pre_out4"}, 32'(if4.busOutputs), 32'(gate(m4v, we)));
        n1 = model_next(m1v, 1, bi, re, inc, dec, clr);
        n4 = model_next(m4v, 4, bi, re, inc, dec, clr);
        e.tag = tag;
        e.v1 = n1[7:0]; e.w1 = n1[8];
        e.v4 = n4[7:0]; e.w4 = n4[8];
        sb.push_back(e);
        m1v = n1[7:0];
        m4v = n4[7:0];
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ":value1"}, 32'(if1.value), 32'(e.v1));
        chk({e.tag, ":wrap1"},  32'(if1.wrap),  32'(e.w1));
        chk({e.tag, ":zero1"},  32'(if1.zero),  32'(e.v1 == 8'h00));
        chk({e.tag, ":out1"},   32'(if1.busOutputs), 32'(gate(e.v1, we)));
        chk({e.tag, ":value4"}, 32'(if4.value), 32'(e.v4));
        chk({e.tag, ":wrap4"},  32'(if4.wrap),  32'(e.w4));
        chk({e.tag, ":zero4"},  32'(if4.zero),  32'(e.v4 == 8'h00));
        chk({e.tag, ":out4"},   32'(if4.busOutputs), 32'(gate(e.v4, we)));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ":value1"}, 32'(if1.value), 32'h0000_00FD);
        chk({tag, ":wrap1"},  32'(if1.wrap),  32'h0);
        chk({tag, ":zero1"},  32'(if1.zero),  32'h0);
        chk({tag, ":out1"},   32'(if1.busOutputs), 32'h0);
        chk({tag, ":value4"}, 32'(if4.value), 32'h0000_00FD);
        chk({tag, ":wrap4"},  32'(if4.wrap),  32'h0);
    endtask

    initial begin
        logic [15:0] rbi;
        logic [1:0]  rre, rwe;
        nrst = 1'b0;
        drive(16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        m1v = 8'hFD;
        m4v = 8'hFD;
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset_init");
        @(negedge clk);
        nrst = 1'b1;

        step("ld_both",  16'h5A33, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("ld_both_lit", 32'(if1.value), 32'h5A);
        step("ld_low",   16'hxx33, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("ld_low_lit", 32'(if1.value), 32'h33);
        step("inc_run",  16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges, with a count request pending.
        @(negedge clk);
        #2;
        drive(16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        nrst = 1'b0;
        #1;
        check_reset("reset_mid");
        m1v = 8'hFD;
        m4v = 8'hFD;
        @(negedge clk);
        drive(16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        nrst = 1'b1;

        step("ld_fe",    16'h00FE, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        step("inc_ff",   16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step("inc_00",   16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("inc_00_lit_wrap", 32'(if1.wrap), 32'h1);
        chk("inc_00_lit_zero", 32'(if1.zero), 32'h1);
        step("inc_01",   16'h0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("inc_01_lit_wrap", 32'(if1.wrap), 32'h0);

        step("ld_02",    16'h0200, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        step("dec_fe",   16'h0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("dec_fe_lit4", 32'(if4.value), 32'hFE);
        chk("dec_fe_lit4_wrap", 32'(if4.wrap), 32'h1);
        step("dec_fa",   16'h0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("dec_fa_lit4", 32'(if4.value), 32'hFA);

        step("ld_10",    16'h0010, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        step("incdec",   16'h0000, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        chk("incdec_lit", 32'(if1.value), 32'h10);
        step("clr_pri",  16'h0077, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("clr_pri_lit", 32'(if1.value), 32'hFD);

        step("ld_c3",    16'h00C3, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        step("gate_10",  16'h0000, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        chk("gate_10_lit", 32'(if1.busOutputs), 32'hC300);
        step("gate_ld",  16'h5500, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0);
        chk("gate_ld_lit", 32'(if1.busOutputs), 32'h5555);

        for (int k = 0; k < 40; k++) begin
            rbi = 16'($urandom);
            rre = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            rwe = 2'($urandom);
            step("rand", rbi, rre, rwe, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

`default_nettype wire
